// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of global-predictor branch predictions.
// Pairs each prediction with its resolved outcome from execute and emits the
// PHT write-back (index + saturating 2-bit counter). A misprediction pulses
// mispredict with the offending PC and squashes every younger entry.
// Optional: define BRQ_PERF_CNT_EN to add perf_resolved / perf_mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic             push_taken,
  input  logic [1:0]       push_ctr,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [6:0]       upd_index,
  output logic [1:0]       upd_ctr,
  output logic             mispredict,
  output logic [31:0]      mispredict_pc,
  output logic             res_err,
  output logic [CNT_W-1:0] count
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_resolved,
  output logic [31:0]      perf_mispredict
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  index;
    logic        taken;
    logic [1:0]  ctr;
  } brq_entry_t;

  brq_entry_t       mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CNT_W-1:0] count_q;

  brq_entry_t       head_e;
  brq_entry_t       push_e;
  logic             do_pop, do_push, mis;
  logic             res_empty;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       ctr_new;

  // PHT index: low 3 bits of the XOR-fold of all eight PC nibbles, above pc[3:0].
  // Only the low 3 fold bits survive in a 7-bit index, so only those are folded.
  function automatic logic [6:0] pht_index(input logic [31:0] pc);
    logic [2:0] f;
    f = '0;
    for (int n = 0; n < 8; n++) f = f ^ pc[n*4 +: 3];
    return {f, pc[3:0]};
  endfunction

  // Saturating 2-bit counter training toward the resolved direction.
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Handshake decode; a mispredict kills a same-cycle push along with the
  // younger entries, and a full queue never pops-then-pushes.
  always_comb begin
    push_ready = (count_q < CNT_W'(DEPTH)) && !reset;
    head_e     = mem[head];
    do_pop     = res_valid && (count_q != '0);
    res_empty  = res_valid && (count_q == '0);
    mis        = do_pop && (res_taken != head_e.taken);
    do_push    = push_valid && push_ready && !mis;
    ctr_new    = ctr_train(head_e.ctr, res_taken);
    push_e.pc    = push_pc;
    push_e.index = pht_index(push_pc);
    push_e.taken = push_taken;
    push_e.ctr   = push_ctr;
    if (mis) count_d = '0;
    else     count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  assign count = count_q;

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_e;
  end

  // Pointers and occupancy; a flush restarts both pointers at slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (mis) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_pop)  head <= head + PW'(1);
      if (do_push) tail <= tail + PW'(1);
      count_q <= count_d;
    end
  end

  // Registered write-back and pulse outputs; index/PC hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid     <= 1'b0;
      upd_index     <= '0;
      upd_ctr       <= '0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      res_err       <= 1'b0;
    end else begin
      upd_valid  <= do_pop;
      mispredict <= mis;
      res_err    <= res_empty;
      if (do_pop) begin
        upd_index <= head_e.index;
        upd_ctr   <= ctr_new;
      end
      if (mis) mispredict_pc <= head_e.pc;
    end
  end

`ifdef BRQ_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_resolved   <= '0;
      perf_mispredict <= '0;
    end else begin
      if (do_pop) perf_resolved   <= perf_resolved + 32'd1;
      if (mis)    perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue (DEPTH=8).
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid, push_ready;
  logic [31:0] push_pc;
  logic        push_taken;
  logic [1:0]  push_ctr;
  logic        res_valid, res_taken;
  logic        upd_valid;
  logic [6:0]  upd_index;
  logic [1:0]  upd_ctr;
  logic        mispredict;
  logic [31:0] mispredict_pc;
  logic        res_err;
  logic [3:0]  count;
`ifdef BRQ_PERF_CNT_EN
  logic [31:0] perf_resolved, perf_mispredict;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_pc [$];
  logic        q_tk [$];
  logic [1:0]  q_ct [$];

  branch_resolve_queue #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_taken(push_taken), .push_ctr(push_ctr),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_ctr(upd_ctr),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .res_err(res_err), .count(count)
`ifdef BRQ_PERF_CNT_EN
    , .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_index(input logic [31:0] pc);
    logic [3:0] f;
    f = pc[31:28] ^ pc[27:24] ^ pc[23:20] ^ pc[19:16] ^
        pc[15:12] ^ pc[11:8]  ^ pc[7:4]   ^ pc[3:0];
    return {f[2:0], pc[3:0]};
  endfunction

  function automatic logic [1:0] ref_ctr(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic push1(input logic [31:0] pc, input logic tk, input logic [1:0] ct);
    push_valid = 1'b1; push_pc = pc; push_taken = tk; push_ctr = ct;
    tick();
    push_valid = 1'b0;
    q_pc.push_back(pc); q_tk.push_back(tk); q_ct.push_back(ct);
  endtask

  // Correctly-predicted resolve of the model head, checked against the model.
  task automatic res_model(input string tag);
    logic [31:0] pc; logic tk; logic [1:0] ct;
    pc = q_pc.pop_front(); tk = q_tk.pop_front(); ct = q_ct.pop_front();
    res_valid = 1'b1; res_taken = tk;
    tick();
    res_valid = 1'b0;
    chk({tag, ".upd_valid"}, 32'(upd_valid), 32'd1);
    chk({tag, ".upd_index"}, 32'(upd_index), 32'(ref_index(pc)));
    chk({tag, ".upd_ctr"},   32'(upd_ctr),   32'(ref_ctr(ct, tk)));
    chk({tag, ".mispredict"}, 32'(mispredict), 32'd0);
  endtask

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_pc = '0; push_taken = 1'b0;
    push_ctr = '0; res_valid = 1'b0; res_taken = 1'b0;

    // Reset state
    tick();
    chk("rst.push_ready", 32'(push_ready), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.upd_valid", 32'(upd_valid), 32'd0);
    chk("rst.upd_index", 32'(upd_index), 32'd0);
    chk("rst.upd_ctr", 32'(upd_ctr), 32'd0);
    chk("rst.mispredict", 32'(mispredict), 32'd0);
    chk("rst.mispredict_pc", mispredict_pc, 32'd0);
    chk("rst.res_err", 32'(res_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.push_ready_after", 32'(push_ready), 32'd1);
    tick();

    // Hit update: 0x1234 -> index 0x44, ctr 10 -> 11
    push1(32'h0000_1234, 1'b1, 2'b10);
    chk("hit.count1", 32'(count), 32'd1);
    void'(q_pc.pop_front()); void'(q_tk.pop_front()); void'(q_ct.pop_front());
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("hit.upd_valid", 32'(upd_valid), 32'd1);
    chk("hit.upd_index", 32'(upd_index), 32'h44);
    chk("hit.upd_ctr", 32'(upd_ctr), 32'd3);
    chk("hit.mispredict", 32'(mispredict), 32'd0);
    chk("hit.count", 32'(count), 32'd0);
    tick();
    chk("hit.upd_valid_drop", 32'(upd_valid), 32'd0);
    chk("hit.upd_index_hold", 32'(upd_index), 32'h44);

    // Saturation at both ends
    push1(32'h0000_0000, 1'b1, 2'b11);
    void'(q_pc.pop_front()); void'(q_tk.pop_front()); void'(q_ct.pop_front());
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("sat_hi.upd_ctr", 32'(upd_ctr), 32'd3);
    chk("sat_hi.upd_index", 32'(upd_index), 32'h00);
    push1(32'h0000_0005, 1'b0, 2'b00);
    void'(q_pc.pop_front()); void'(q_tk.pop_front()); void'(q_ct.pop_front());
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("sat_lo.upd_ctr", 32'(upd_ctr), 32'd0);
    chk("sat_lo.upd_index", 32'(upd_index), 32'h55);
    chk("sat_lo.mispredict", 32'(mispredict), 32'd0);

    // Mispredict flush with a same-cycle push that must be dropped
    push_valid = 1'b1; push_taken = 1'b1; push_ctr = 2'b10;
    push_pc = 32'h100; tick();
    push_pc = 32'h104; tick();
    push_pc = 32'h108; tick();
    chk("mis.count3", 32'(count), 32'd3);
    push_pc = 32'h10C; res_valid = 1'b1; res_taken = 1'b0;
    tick();
    push_valid = 1'b0; res_valid = 1'b0;
    chk("mis.mispredict", 32'(mispredict), 32'd1);
    chk("mis.mispredict_pc", mispredict_pc, 32'h100);
    chk("mis.upd_valid", 32'(upd_valid), 32'd1);
    chk("mis.upd_index", 32'(upd_index), 32'h10);
    chk("mis.upd_ctr", 32'(upd_ctr), 32'd1);
    chk("mis.count", 32'(count), 32'd0);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("mis.res_err", 32'(res_err), 32'd1);
    chk("mis.no_upd", 32'(upd_valid), 32'd0);
    chk("mis.mispredict_drop", 32'(mispredict), 32'd0);
    chk("mis.pc_hold", mispredict_pc, 32'h100);
    chk("mis.count_empty", 32'(count), 32'd0);
    tick();
    chk("mis.res_err_drop", 32'(res_err), 32'd0);

    // Fill to full
    for (int i = 0; i < 8; i++)
      push1(32'h2000 + 32'(i) * 32'h44, i[0], i[1:0]);
    chk("full.count", 32'(count), 32'd8);
    chk("full.push_ready", 32'(push_ready), 32'd0);
    // Push+resolve on full: push rejected
    push_valid = 1'b1; push_pc = 32'hDEAD; push_taken = 1'b0; push_ctr = 2'b01;
    begin
      logic [31:0] pc; logic tk; logic [1:0] ct;
      pc = q_pc.pop_front(); tk = q_tk.pop_front(); ct = q_ct.pop_front();
      res_valid = 1'b1; res_taken = tk;
      tick();
      push_valid = 1'b0; res_valid = 1'b0;
      chk("full.count7", 32'(count), 32'd7);
      chk("full.upd_index", 32'(upd_index), 32'(ref_index(pc)));
      chk("full.upd_ctr", 32'(upd_ctr), 32'(ref_ctr(ct, tk)));
    end
    // Alternating push/resolve across the pointer wrap
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) push1(32'h3000 + 32'(k) * 32'h111, k[1], k[2:1]);
      else            res_model($sformatf("wrap%0d", k));
    end
    chk("wrap.count", 32'(count), 32'd7);
    res_model("drain0");
    res_model("drain1");
    chk("pre_rst.count", 32'(count), 32'd5);

    // Reset mid-operation drops all entries
    reset = 1'b1;
    tick();
    chk("mrst.push_ready", 32'(push_ready), 32'd0);
    chk("mrst.count", 32'(count), 32'd0);
    chk("mrst.upd_valid", 32'(upd_valid), 32'd0);
    chk("mrst.mispredict", 32'(mispredict), 32'd0);
    chk("mrst.res_err", 32'(res_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst.push_ready_after", 32'(push_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("mrst.no_upd", 32'(upd_valid), 32'd0);
      chk("mrst.count_stay", 32'(count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions made by the global predictor, paired with resolved outcomes arriving from execute.
- On each resolution it produces the PHT write-back: index plus 2-bit saturating counter update.
- It also flags mispredictions and squashes younger queued predictions.
- This is the update/write side of the predictor, which has none of its own.

Parameters:
- DEPTH, 8: queue entries; power of two, 2 to 64.
- CNT_W, 4: width of `count`; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- push_valid  in  1  fetch offers a predicted branch
- push_ready  out  1  queue can accept a push this cycle
- push_pc  in  32  branch PC
- push_taken  in  1  predicted direction (1 = taken)
- push_ctr  in  2  PHT counter value read at predict time
- res_valid  in  1  execute resolves the oldest branch
- res_taken  in  1  actual direction
- upd_valid  out  1  PHT write strobe
- upd_index  out  7  PHT write index
- upd_ctr  out  2  new counter value
- mispredict  out  1  one-cycle pulse on misprediction
- mispredict_pc  out  32  PC of the mispredicted branch
- res_err  out  1  one-cycle pulse: resolve arrived while the queue was empty
- count  out  CNT_W  current occupancy

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears head and tail pointers; count=0.
  - upd_valid, mispredict and res_err = 0; upd_index, upd_ctr and mispredict_pc = 0.
  - push_ready=0 while reset is high, 1 on the first cycle after.
  - Reset mid-operation discards all entries; no update is emitted for them.
- Storage:
  - Circular buffer, DEPTH entries.
  - Each entry holds {pc[31:0], index[6:0], taken, ctr[1:0]}.
  - index is computed at push time: fold = XOR of the eight PC nibbles pc[31:28] .. pc[3:0]; index = {fold, pc[3:0]}.
- Push:
  - Accepted when push_valid && push_ready.
  - push_ready = (count < DEPTH) && !reset.
  - When full, push_ready stays 0 even if a resolve occurs in the same cycle; there is no pop-then-push on full.
- Resolve:
  - res_valid with count>0 pops the head.
  - res_valid with count==0 has no state change and pulses res_err the next cycle.
- Update (registered, 1-cycle latency after the resolve cycle):
  - upd_valid=1 and upd_index = head.index.
  - upd_ctr = head.ctr+1 saturating at 2'b11 if res_taken, else head.ctr-1 saturating at 2'b00.
- Mispredict detection: res_taken != head.taken.
  - Next cycle: mispredict=1 and mispredict_pc = head.pc; the upd_* write is still emitted.
  - count=0 next cycle; all younger entries are squashed.
  - A push in the same cycle as a mispredicting resolve is discarded.
- Simultaneous push and non-mispredicting resolve (not full): both take effect; count is unchanged.
- Pointer wrap-around: modulo DEPTH.
- Outputs are held only for the single pulse cycle, then return to 0. mispredict_pc and upd_index hold their last values.

Optional Feature:
- Macro: BRQ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_resolved (out, 32) and perf_mispredict (out, 32).
  - perf_resolved increments on every successful pop; perf_mispredict increments on every mispredict.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and the counter logic are absent. Core behaviour is identical either way.

Test Plan:
- Hit update: push pc=0x00001234, taken=1, ctr=2'b10; resolve taken=1 -> next cycle upd_valid=1, upd_index=7'h44, upd_ctr=2'b11, mispredict=0, count=0.
- Saturation:
  - Push ctr=2'b11 taken=1, resolve taken=1 -> upd_ctr=2'b11.
  - Push ctr=2'b00 taken=0, resolve taken=0 -> upd_ctr=2'b00.
- Mispredict flush:
  - Push pc=0x100, 0x104, 0x108 (taken=1, ctr=2'b10); resolve taken=0 with a simultaneous push of pc=0x10C.
  - Next cycle: mispredict=1, mispredict_pc=0x100, upd_ctr=2'b01, count=0.
  - A following resolve -> res_err=1.
- Full/wrap:
  - DEPTH=8: 8 pushes -> push_ready=0.
  - Push+resolve in the same cycle -> push rejected, count=7.
  - 20 further alternating push/resolve cycles -> results come out in FIFO order across the wrap.
- Reset mid-operation: with count=5, assert reset one cycle -> count=0 and all pulse outputs 0; push_ready=0 during reset, 1 after; no upd_valid is emitted for the dropped entries.
